// File: rtl/uart_loader_pkg.sv
// Shared state encodings and width helper for the UART program loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_IMEM = 2'd0,
        LOAD_DMEM = 2'd1,
        DONE      = 2'd2
    } load_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic int addr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch-rejecting start detect, framing-error pulse.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic       rvalid_o,
    output logic [7:0] rdata_o,
    output logic       ferr_o
);

    localparam int CPB = CLK_FREQ_MHZ * 1_000_000 / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

    logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rvalid_q, rvalid_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ferr_q, ferr_d;
    logic            cnt_done;

    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            // A start bit that is gone by mid-bit is treated as line noise.
            START: begin
                if (cnt_done) begin
                    if (!rxd_s2_q) begin
                        state_d = DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_done) begin
                    shreg_d = {rxd_s2_q, shreg_q[7:1]};
                    cnt_d   = FULL_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    if (rxd_s2_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = shreg_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            rdata_q    <= 8'h00;
            ferr_q     <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd_i;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign ferr_o   = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// Program loader: assembles little-endian words from UART bytes, fills imem then dram,
// and holds the CPU in reset until done_o.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 1000000,
    parameter int IMEM_ENTRIES = 4096,
    parameter int DMEM_ENTRIES = 4096,
    localparam int IA = addr_width(IMEM_ENTRIES),
    localparam int DA = addr_width(DMEM_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rxd_i,
    output logic          imem_we_o,
    output logic [IA-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          dmem_we_o,
    output logic [DA-1:0] dmem_addr_o,
    output logic [31:0]   dmem_wdata_o,
    output logic          done_o,
    output logic          frame_err_o
);

    localparam int WW = (IA > DA) ? IA : DA;
    localparam logic [WW-1:0] IMEM_LAST = WW'(IMEM_ENTRIES - 1);
    localparam logic [WW-1:0] DMEM_LAST = WW'(DMEM_ENTRIES - 1);

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ferr;

    load_state_e   ld_q, ld_d;
    logic [1:0]    bp_q, bp_d;
    logic [WW-1:0] word_q, word_d;
    logic [23:0]   asm_q, asm_d;
    logic          imem_we_q, imem_we_d;
    logic [IA-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;
    logic          dmem_we_q, dmem_we_d;
    logic [DA-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;

    uart_rx #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
        .BAUD_RATE   (BAUD_RATE)
    ) u_rx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .rxd_i   (rxd_i),
        .rvalid_o(rx_valid),
        .rdata_o (rx_data),
        .ferr_o  (rx_ferr)
    );

    always_comb begin
        ld_d         = ld_q;
        bp_d         = bp_q;
        word_d       = word_q;
        asm_d        = asm_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        done_d       = done_q | (ld_q == DONE);
        frame_err_d  = frame_err_q | rx_ferr;
        // The fourth byte goes straight into wdata; only three lanes need storage.
        if (rx_valid && (ld_q != DONE)) begin
            bp_d = bp_q + 2'd1;
            if (bp_q == 2'd0) begin
                asm_d[7:0] = rx_data;
            end else if (bp_q == 2'd1) begin
                asm_d[15:8] = rx_data;
            end else if (bp_q == 2'd2) begin
                asm_d[23:16] = rx_data;
            end else if (ld_q == LOAD_IMEM) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = word_q[IA-1:0];
                imem_wdata_d = {rx_data, asm_q};
                if (word_q == IMEM_LAST) begin
                    ld_d   = LOAD_DMEM;
                    word_d = '0;
                end else begin
                    word_d = word_q + WW'(1);
                end
            end else begin
                dmem_we_d    = 1'b1;
                dmem_addr_d  = word_q[DA-1:0];
                dmem_wdata_d = {rx_data, asm_q};
                if (word_q == DMEM_LAST) begin
                    ld_d   = DONE;
                    word_d = '0;
                end else begin
                    word_d = word_q + WW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_q         <= LOAD_IMEM;
            bp_q         <= 2'd0;
            word_q       <= '0;
            asm_q        <= 24'h0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'h0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ld_q         <= ld_d;
            bp_q         <= bp_d;
            word_q       <= word_d;
            asm_q        <= asm_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign done_o       = done_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: UART byte driver, write monitor and a
// byte-stream-to-memory-image reference model.
module tb_uart_loader;

    localparam int CLK_MHZ = 10;
    localparam int BAUD    = 1_000_000;
    localparam int CPB     = 10;
    localparam int IMEM_N  = 4;
    localparam int DMEM_N  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [0:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        done;
    logic        ferr;

    typedef struct {
        bit          dm;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        seen_q[$];
    wr_t        exp_q[$];
    logic [7:0] bytes_q[$];
    int         cyc       = 0;
    int         done_rise = -1;
    bit         done_prev = 1'b0;
    int         rule_err  = 0;
    int         checks    = 0;
    int         passed    = 0;
    int         fails     = 0;

    uart_loader #(
        .CLK_FREQ_MHZ(CLK_MHZ),
        .BAUD_RATE   (BAUD),
        .IMEM_ENTRIES(IMEM_N),
        .DMEM_ENTRIES(DMEM_N)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rxd_i       (rxd),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .dmem_we_o   (dmem_we),
        .dmem_addr_o (dmem_addr),
        .dmem_wdata_o(dmem_wdata),
        .done_o      (done),
        .frame_err_o (ferr)
    );

    always #5 clk = ~clk;

    // Record every write strobe and the cycle done_o first rises.
    always @(negedge clk) begin
        cyc++;
        if (imem_we) seen_q.push_back('{dm: 1'b0, addr: int'(imem_addr), data: imem_wdata, cyc: cyc});
        if (dmem_we) seen_q.push_back('{dm: 1'b1, addr: int'(dmem_addr), data: dmem_wdata, cyc: cyc});
        if ((imem_we && dmem_we) || ((imem_we || dmem_we) && done)) rule_err++;
        if (done && !done_prev) done_rise = cyc;
        done_prev = done;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int gap);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendBytes(input int gap_min, input int gap_max);
        foreach (bytes_q[i]) applyStimulus(bytes_q[i], 1'b1, int'($urandom_range(gap_max, gap_min)));
        repeat (30) @(negedge clk);
    endtask

    // Reference: consecutive groups of four bytes form little-endian words;
    // the first IMEM_N words go to imem, the next DMEM_N to dram, the rest are dropped.
    task automatic buildExpected();
        exp_q.delete();
        for (int w = 0; 4 * w + 3 < bytes_q.size(); w++) begin
            logic [31:0] word;
            word = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
            if (w < IMEM_N)
                exp_q.push_back('{dm: 1'b0, addr: w, data: word, cyc: 0});
            else if (w < IMEM_N + DMEM_N)
                exp_q.push_back('{dm: 1'b1, addr: w - IMEM_N, data: word, cyc: 0});
        end
    endtask

    task automatic compareWrites(input string tag);
        buildExpected();
        checkOutput({tag, "_count"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            checkOutput($sformatf("%s_mem%0d", tag, i), seen_q[i].dm, exp_q[i].dm);
            checkOutput($sformatf("%s_addr%0d", tag, i), seen_q[i].addr, exp_q[i].addr);
            checkOutput($sformatf("%s_data%0d", tag, i), seen_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_imem_we"}, imem_we, 0);
        checkOutput({tag, "_imem_addr"}, imem_addr, 0);
        checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
        checkOutput({tag, "_dmem_we"}, dmem_we, 0);
        checkOutput({tag, "_dmem_addr"}, dmem_addr, 0);
        checkOutput({tag, "_dmem_wdata"}, dmem_wdata, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_ferr"}, ferr, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        seen_q.delete();
        done_rise = -1;
    endtask

    task automatic checkDoneTiming(input string tag);
        checkOutput({tag, "_done"}, done, 1);
        if (seen_q.size() > 0)
            checkOutput({tag, "_done_rise"}, done_rise, seen_q[seen_q.size()-1].cyc + 1);
        checkOutput({tag, "_strobe_rules"}, rule_err, 0);
    endtask

    initial begin
        rxd   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Glitch rejection, then a real 0xA5 completes word 0 with three more bytes.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_write", seen_q.size(), 0);
        checkOutput("glitch_no_ferr", ferr, 0);
        bytes_q = {8'hA5, 8'($urandom), 8'($urandom), 8'($urandom)};
        sendBytes(2, 4);
        compareWrites("glitch_a5");

        // Framing error: sticky flag, byte dropped without advancing the lane.
        doReset();
        applyStimulus(8'h55, 1'b0, 3);
        repeat (20) @(negedge clk);
        checkOutput("ferr_set", ferr, 1);
        checkOutput("ferr_no_write", seen_q.size(), 0);
        bytes_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        sendBytes(1, 5);
        checkOutput("ferr_sticky", ferr, 1);
        compareWrites("ferr_word");

        // Reset in the middle of a load.
        doReset();
        bytes_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        sendBytes(1, 3);
        checkOutput("midload_one_write", seen_q.size(), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("midload_in_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("midload_after");
        seen_q.delete();
        done_rise = -1;

        // Full image load 00..17 with random inter-byte gaps.
        bytes_q.delete();
        for (int i = 0; i < 24; i++) bytes_q.push_back(8'(i));
        sendBytes(1, 6);
        compareWrites("full");
        checkDoneTiming("full");
        checkOutput("full_imem_addr_held", imem_addr, 3);
        checkOutput("full_imem_wdata_held", imem_wdata, 32'h0F0E0D0C);
        checkOutput("full_dmem_addr_held", dmem_addr, 1);
        checkOutput("full_dmem_wdata_held", dmem_wdata, 32'h17161514);

        // Bytes after done are ignored.
        bytes_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        sendBytes(1, 3);
        checkOutput("post_done_strobes", seen_q.size(), IMEM_N + DMEM_N);
        checkOutput("post_done_done", done, 1);
        checkOutput("post_done_rules", rule_err, 0);

        // Back-to-back random bytes with the minimum one-cycle gap.
        doReset();
        bytes_q.delete();
        for (int i = 0; i < 24; i++) bytes_q.push_back(8'($urandom));
        sendBytes(1, 1);
        compareWrites("b2b");
        checkDoneTiming("b2b");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
